// File: rtl/day10_machine_scheduler.sv
// Dispatches parsed machine records from a reader to a pool of solver slots
// in round-robin order and accumulates the returned press counts.
module day10_machine_scheduler #(
  parameter int unsigned NUM_SOLVERS = 2,
  parameter int unsigned PRESS_W     = 8,
  parameter int unsigned RESULT_W    = 32,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  output logic                           reader_start,
  input  logic                           reader_ready,
  input  logic                           end_of_input,
  output logic [NUM_SOLVERS-1:0]         load,
  input  logic [NUM_SOLVERS-1:0]         solver_done,
  input  logic [NUM_SOLVERS*PRESS_W-1:0] solver_presses,
  output logic [RESULT_W-1:0]            total,
  output logic                           total_valid,
  output logic [COUNT_W-1:0]             machine_count,
  output logic                           busy
);

  localparam int unsigned IDX_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SOLVERS-1:0] slot_busy_q, slot_busy_d;
  logic [RESULT_W-1:0]    total_q, total_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       tgt_q, tgt_d;

  logic [RESULT_W-1:0]    done_sum;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_found;
  int unsigned            probe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      slot_busy_q <= '0;
      total_q     <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      tgt_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_busy_q <= slot_busy_d;
      total_q     <= total_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      tgt_q       <= tgt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_busy_d  = slot_busy_q & ~solver_done;
    count_d      = count_q;
    ptr_d        = ptr_q;
    tgt_d        = tgt_q;
    reader_start = 1'b0;
    load         = '0;
    done_sum     = '0;
    sel_idx      = '0;
    sel_found    = 1'b0;
    probe        = 0;

    // Completions from busy slots only; spurious dones on free slots add nothing.
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      if (slot_busy_q[i] && solver_done[i]) begin
        done_sum = done_sum + RESULT_W'(solver_presses[i*PRESS_W +: PRESS_W]);
      end
    end
    total_d = total_q + done_sum;

    // Registered busy bits are searched, so a slot freed this cycle waits one cycle.
    for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
      probe = 32'(ptr_q) + k;
      if (probe >= NUM_SOLVERS) begin
        probe = probe - NUM_SOLVERS;
      end
      if (!sel_found && !slot_busy_q[probe]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(probe);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d = S_ISSUE;
          total_d = '0;
          count_d = '0;
          ptr_d   = '0;
        end
      end
      S_ISSUE: begin
        if (end_of_input) begin
          state_d = S_DRAIN;
        end else if (sel_found) begin
          reader_start = 1'b1;
          tgt_d        = sel_idx;
          state_d      = S_WAIT_READ;
        end
      end
      S_WAIT_READ: begin
        if (reader_ready) begin
          for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
            if (IDX_W'(i) == tgt_q) begin
              load[i]        = 1'b1;
              slot_busy_d[i] = 1'b1;
            end
          end
          count_d = count_q + COUNT_W'(1);
          ptr_d   = (tgt_q == IDX_W'(NUM_SOLVERS - 1)) ? '0 : tgt_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (slot_busy_d == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from state, so suppress them while reset is held.
    if (rst) begin
      reader_start = 1'b0;
      load         = '0;
    end
  end

  assign total         = total_q;
  assign machine_count = count_q;
  assign total_valid   = !rst && (state_q == S_DONE);
  assign busy          = !rst && (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_day10_machine_scheduler.sv
// Directed cycle-by-cycle bench for the two-slot machine scheduler.
module tb_day10_machine_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        reader_start;
  logic        reader_ready;
  logic        end_of_input;
  logic [1:0]  load;
  logic [1:0]  solver_done;
  logic [15:0] solver_presses;
  logic [31:0] total;
  logic        total_valid;
  logic [15:0] machine_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  day10_machine_scheduler #(
    .NUM_SOLVERS(2), .PRESS_W(8), .RESULT_W(32), .COUNT_W(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .go             (go),
    .reader_start   (reader_start),
    .reader_ready   (reader_ready),
    .end_of_input   (end_of_input),
    .load           (load),
    .solver_done    (solver_done),
    .solver_presses (solver_presses),
    .total          (total),
    .total_valid    (total_valid),
    .machine_count  (machine_count),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic done_pulse(input logic [1:0] mask, input logic [7:0] v1, input logic [7:0] v0);
    solver_done    = mask;
    solver_presses = {v1, v0};
    step();
    solver_done    = 2'b00;
    solver_presses = 16'h0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; reader_ready = 1'b0; end_of_input = 1'b0;
    solver_done = 2'b00; solver_presses = 16'h0;
    step(); step();
    settle();
    chk("rst_reader_start", 64'(reader_start), 64'd0);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(total_valid), 64'd0);
    chk("rst_total", 64'(total), 64'd0);
    chk("rst_count", 64'(machine_count), 64'd0);
    rst = 1'b0;
    step();

    // Basic run: three records, results 2, 3, 5.
    go = 1'b1; step(); go = 1'b0; settle();
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_start0", 64'(reader_start), 64'd1);
    step(); settle();
    chk("basic_wait_nostart", 64'(reader_start), 64'd0);
    chk("basic_wait_noload", 64'(load), 64'd0);
    reader_ready = 1'b1; settle();
    chk("basic_load0", 64'(load), 64'd1);
    step(); reader_ready = 1'b0; settle();
    chk("basic_start1", 64'(reader_start), 64'd1);
    step(); reader_ready = 1'b1; settle();
    chk("basic_load1", 64'(load), 64'd2);
    step(); reader_ready = 1'b0; settle();
    chk("basic_full_nostart", 64'(reader_start), 64'd0);
    solver_done = 2'b01; solver_presses = {8'd0, 8'd2}; settle();
    chk("basic_freed_same_cycle", 64'(reader_start), 64'd0);
    step(); solver_done = 2'b00; solver_presses = 16'h0; settle();
    chk("basic_total2", 64'(total), 64'd2);
    chk("basic_start2", 64'(reader_start), 64'd1);
    step(); reader_ready = 1'b1; settle();
    chk("basic_load2", 64'(load), 64'd1);
    step(); reader_ready = 1'b0; end_of_input = 1'b1; settle();
    chk("basic_eoi_nostart", 64'(reader_start), 64'd0);
    chk("basic_count3", 64'(machine_count), 64'd3);
    step(); settle();
    chk("basic_drain_busy", 64'(busy), 64'd1);
    done_pulse(2'b10, 8'd3, 8'd0); settle();
    chk("basic_drain_total5", 64'(total), 64'd5);
    chk("basic_drain_notvalid", 64'(total_valid), 64'd0);
    done_pulse(2'b01, 8'd0, 8'd5); settle();
    chk("basic_done_valid", 64'(total_valid), 64'd1);
    chk("basic_done_busy", 64'(busy), 64'd0);
    chk("basic_total10", 64'(total), 64'd10);
    step(); step(); settle();
    chk("basic_hold_total", 64'(total), 64'd10);
    chk("basic_hold_count", 64'(machine_count), 64'd3);

    // Backpressure: fill both slots, then starve for 20 cycles.
    end_of_input = 1'b0;
    go = 1'b1; step(); go = 1'b0; settle();
    chk("bp_total_cleared", 64'(total), 64'd0);
    chk("bp_count_cleared", 64'(machine_count), 64'd0);
    step(); reader_ready = 1'b1; settle();
    chk("bp_load0", 64'(load), 64'd1);
    step(); reader_ready = 1'b0;
    step(); reader_ready = 1'b1; settle();
    chk("bp_load1", 64'(load), 64'd2);
    step(); reader_ready = 1'b0;
    begin
      int starts;
      starts = 0;
      for (int c = 0; c < 20; c++) begin
        settle();
        if (reader_start) starts++;
        step();
      end
      chk("bp_no_start_20", 64'(starts), 64'd0);
    end
    done_pulse(2'b10, 8'd4, 8'd0); settle();
    chk("bp_start_after_done", 64'(reader_start), 64'd1);
    chk("bp_total4", 64'(total), 64'd4);
    step(); reader_ready = 1'b1; settle();
    chk("bp_target_slot1", 64'(load), 64'd2);
    step(); reader_ready = 1'b0;

    // Simultaneous completion: 7 + 9 in one cycle.
    done_pulse(2'b11, 8'd9, 8'd7); settle();
    chk("sim_total20", 64'(total), 64'd20);

    // Spurious done on free slot 1.
    done_pulse(2'b10, 8'd200, 8'd0); settle();
    chk("spur_total_unchanged", 64'(total), 64'd20);
    step(); settle();
    chk("wait_hold_noload", 64'(load), 64'd0);
    chk("wait_hold_nostart", 64'(reader_start), 64'd0);
    end_of_input = 1'b1; reader_ready = 1'b1; settle();
    chk("spur_load0", 64'(load), 64'd1);
    step(); reader_ready = 1'b0;
    step(); settle();
    chk("spur_drain_busy", 64'(busy), 64'd1);
    done_pulse(2'b01, 8'd0, 8'd1); settle();
    chk("spur_done_valid", 64'(total_valid), 64'd1);
    chk("spur_total21", 64'(total), 64'd21);
    chk("spur_count4", 64'(machine_count), 64'd4);
    reader_ready = 1'b1; step(); reader_ready = 1'b0; settle();
    chk("ready_outside_wait", 64'(machine_count), 64'd4);

    // Empty input: go with end_of_input already high.
    go = 1'b1; step(); go = 1'b0; settle();
    chk("empty_issue_nostart", 64'(reader_start), 64'd0);
    chk("empty_issue_busy", 64'(busy), 64'd1);
    step(); settle();
    chk("empty_drain_nostart", 64'(reader_start), 64'd0);
    step(); settle();
    chk("empty_done_valid", 64'(total_valid), 64'd1);
    chk("empty_total0", 64'(total), 64'd0);
    chk("empty_count0", 64'(machine_count), 64'd0);

    // Reset mid-run with both slots busy and total 12.
    end_of_input = 1'b0;
    go = 1'b1; step(); go = 1'b0;
    step(); reader_ready = 1'b1; step(); reader_ready = 1'b0;
    step(); reader_ready = 1'b1; step(); reader_ready = 1'b0;
    done_pulse(2'b01, 8'd0, 8'd12);
    step(); reader_ready = 1'b1; settle();
    chk("mid_reload0", 64'(load), 64'd1);
    step(); reader_ready = 1'b0; settle();
    chk("mid_total12", 64'(total), 64'd12);
    rst = 1'b1; step(); settle();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_total", 64'(total), 64'd0);
    chk("mid_rst_count", 64'(machine_count), 64'd0);
    chk("mid_rst_valid", 64'(total_valid), 64'd0);
    chk("mid_rst_start", 64'(reader_start), 64'd0);
    rst = 1'b0;
    done_pulse(2'b11, 8'd5, 8'd5); settle();
    chk("mid_late_done_ignored", 64'(total), 64'd0);
    chk("mid_idle_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/day10_machine_scheduler.md
DAY10_MACHINE_SCHEDULER -- requirements
Module: day10_machine_scheduler

Interface
REQ-001 SHALL have parameter NUM_SOLVERS, default 2: number of solver slots, range 1..8.
REQ-002 SHALL have parameter PRESS_W, default 8: width of each per-machine press count.
REQ-003 SHALL have parameter RESULT_W, default 32: width of the accumulated total.
REQ-004 SHALL have parameter COUNT_W, default 16: width of the dispatched-machine counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port go  input  1  single-cycle pulse that starts a run; sampled only in IDLE and DONE.
REQ-009 SHALL have port reader_start  output  1  one-cycle start pulse to the input reader.
REQ-010 SHALL have port reader_ready  input  1  one-cycle pulse from the reader: a parsed machine record is valid.
REQ-011 SHALL have port end_of_input  input  1  level from the reader: the last record has been consumed.
REQ-012 SHALL have port load  output  NUM_SOLVERS  one-hot strobe that copies the current record into slot i.
REQ-013 SHALL have port solver_done  input  NUM_SOLVERS  per-slot one-cycle completion pulse.
REQ-014 SHALL have port solver_presses  input  NUM_SOLVERS*PRESS_W  slot i result in bits [i*PRESS_W +: PRESS_W]; valid with solver_done[i].
REQ-015 SHALL have port total  output  RESULT_W  accumulated press sum.
REQ-016 SHALL have port total_valid  output  1  high while in DONE.
REQ-017 SHALL have port machine_count  output  COUNT_W  number of records dispatched in the current run.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE and DONE.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_READ, DRAIN and DONE.
REQ-020 SHALL keep a slot_busy bit per slot; a slot is free when its bit is 0.
REQ-021 In IDLE or DONE, on go: SHALL go to ISSUE; clear total, machine_count and the round-robin pointer on the same edge.
REQ-022 In ISSUE with end_of_input=1: SHALL go to DRAIN.
REQ-023 In ISSUE with end_of_input=0 and at least one free slot: SHALL assert reader_start for exactly one cycle, latch the target slot, and go to WAIT_READ.
REQ-024 Target slot SHALL be the first free slot found searching upward from the round-robin pointer, wrapping modulo NUM_SOLVERS.
REQ-025 In ISSUE with no free slot: SHALL stay in ISSUE with reader_start=0.
REQ-026 In WAIT_READ, on reader_ready: SHALL assert load[target] for that same cycle.
REQ-027 On the same reader_ready edge: SHALL set slot_busy[target], increment machine_count (wrapping), set the pointer to target+1 mod NUM_SOLVERS, and go to ISSUE.
REQ-028 In WAIT_READ with reader_ready=0: SHALL hold state and assert no load bit.
REQ-029 In any state, for each slot with slot_busy[i]=1 and solver_done[i]=1: SHALL clear slot_busy[i] and add that slot's zero-extended solver_presses to total on that edge.
REQ-030 Simultaneous dones from several slots SHALL all be added in one cycle; total wraps modulo 2^RESULT_W.
REQ-031 solver_done[i] while slot_busy[i]=0 SHALL be ignored (no add, no state change).
REQ-032 A slot freed by solver_done in cycle N SHALL be eligible for selection in ISSUE at cycle N+1, not in cycle N.
REQ-033 In DRAIN: SHALL go to DONE when all slot_busy bits are 0, including the cycle in which the last done clears them.
REQ-034 DONE SHALL hold total and machine_count stable with total_valid=1 until go.
REQ-035 reader_ready outside WAIT_READ SHALL be ignored.
REQ-036 Latencies SHALL be: go to first reader_start, 1 cycle; reader_ready to next reader_start (free slot available), 1 cycle.

Reset
REQ-037 While rst=1: state SHALL be IDLE; all slot_busy bits, total, machine_count and the pointer SHALL be 0.
REQ-038 While rst=1: reader_start, load, total_valid and busy SHALL be 0.
REQ-039 rst asserted mid-run SHALL abandon all in-flight slots with no accumulation of their results.

Verification
REQ-040 Basic run: NUM_SOLVERS=2; go; 3 records; solvers return 2, 3, 5 -> loads to slots 0,1,0; DONE with total=10, machine_count=3.
REQ-041 Backpressure: both slots busy, no done for 20 cycles -> reader_start stays 0; done[1] with value 4 -> reader_start on the next cycle, target slot 1.
REQ-042 Simultaneous completion: done[0]=1 (value 7) and done[1]=1 (value 9) in the same cycle -> total increases by 16 in one cycle.
REQ-043 Spurious done: done[1] with value 200 while slot 1 is free -> total unchanged.
REQ-044 Empty input: end_of_input=1 at go -> ISSUE, DRAIN, DONE with total=0, machine_count=0, and no reader_start.
REQ-045 Reset mid-run: rst asserted with 2 slots busy and total=12 -> next cycle IDLE with all outputs 0; a later done is ignored.
